// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - pointer coding helpers shared by both sides of the async FIFO
package async_fifo_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // Helpers work on 32-bit zero-extended pointers; callers cast back to AW+1 bits.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
  function automatic logic full_cmp(input logic [31:0] wr_gray,
                                    input logic [31:0] rd_gray,
                                    input int          aw);
    logic [31:0] mask;
    mask = 32'd3 << (aw - 1);
    return wr_gray == (rd_gray ^ mask);
  endfunction

endpackage

// File: rtl/async_fifo_gray_sync.sv
// rtl/async_fifo_gray_sync.sv - multi-flop synchronizer for a Gray-coded pointer
module async_fifo_gray_sync
  import async_fifo_pkg::*;
#(
  parameter int W      = 6,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("async_fifo_gray_sync: STAGES out of range");
  end

  logic [W-1:0] chain [STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        chain[i] <= '0;
      end
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/async_fifo_write_side_ctrl.sv
// rtl/async_fifo_write_side_ctrl.sv - write-domain pointer, full and occupancy control of the async FIFO
module async_fifo_write_side_ctrl
  import async_fifo_pkg::*;
#(
  parameter int AW          = 5,
  parameter int DW          = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en_dft,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          ram_we,
  output logic [AW-1:0] ram_wa,
  output logic [DW-1:0] ram_wd,
  output logic [AW:0]   wr_ptr_gray,
  input  logic [AW:0]   rd_ptr_gray,
  output logic [AW:0]   wr_count
);

  logic [AW:0] wr_ptr_bin;
  logic [AW:0] next_wr_bin;
  logic [AW:0] next_wr_gray;
  logic [AW:0] rd_sync_gray;
  logic [AW:0] rd_sync_bin;
  logic        full_q;
  logic        full_next;
  logic        transfer;

  async_fifo_gray_sync #(
    .W      (AW + 1),
    .STAGES (SYNC_STAGES)
  ) u_rd_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rd_ptr_gray),
    .q     (rd_sync_gray)
  );

  assign wr_prdy  = !full_q & wr_en_dft;
  assign transfer = wr_pvld & wr_prdy;
  assign ram_we   = transfer;
  assign ram_wa   = wr_ptr_bin[AW-1:0];
  assign ram_wd   = wr_pd;

  always_comb begin
    next_wr_bin  = wr_ptr_bin + {{AW{1'b0}}, transfer};
    next_wr_gray = (AW + 1)'(bin2gray(32'(next_wr_bin)));
    rd_sync_bin  = (AW + 1)'(gray2bin(32'(rd_sync_gray)));
    full_next    = full_cmp(32'(next_wr_gray), 32'(rd_sync_gray), AW);
  end

  // full_q resets high so nothing is accepted until the first post-reset edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_bin  <= '0;
      wr_ptr_gray <= '0;
      wr_count    <= '0;
      full_q      <= 1'b1;
    end else begin
      wr_ptr_bin  <= next_wr_bin;
      wr_ptr_gray <= next_wr_gray;
      wr_count    <= next_wr_bin - rd_sync_bin;
      full_q      <= full_next;
    end
  end

endmodule

// File: tb/tb_async_fifo_write_side_ctrl.sv
// tb/tb_async_fifo_write_side_ctrl.sv - scoreboard bench for the async FIFO write-side controller
module tb_async_fifo_write_side_ctrl;

  localparam int AW    = 2;
  localparam int DW    = 8;
  localparam int SS    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en_dft = 1'b1;
  logic          wr_pvld = 1'b0;
  logic [DW-1:0] wr_pd = '0;
  logic [AW:0]   rd_ptr_gray = '0;
  logic          wr_prdy;
  logic          ram_we;
  logic [AW-1:0] ram_wa;
  logic [DW-1:0] ram_wd;
  logic [AW:0]   wr_ptr_gray;
  logic [AW:0]   wr_count;

  async_fifo_write_side_ctrl #(.AW(AW), .DW(DW), .SYNC_STAGES(SS)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en_dft   (wr_en_dft),
    .wr_pvld     (wr_pvld),
    .wr_prdy     (wr_prdy),
    .wr_pd       (wr_pd),
    .ram_we      (ram_we),
    .ram_wa      (ram_wa),
    .ram_wd      (ram_wd),
    .wr_ptr_gray (wr_ptr_gray),
    .rd_ptr_gray (rd_ptr_gray),
    .wr_count    (wr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_w;
  int          checks = 0;
  int          errors = 0;
  logic [AW:0] wr_model = '0;
  logic [AW:0] rd_model = '0;
  logic [AW:0] prev_gray = '0;
  logic [AW:0] hold_gray;

  function automatic logic [AW:0] to_gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_write(input logic [DW-1:0] data);
    exp_q.push_back('{wa: wr_model[AW-1:0], wd: data});
    wr_model = wr_model + 1'b1;
    wr_pd    = data;
    wr_pvld  = 1'b1;
  endtask

  task automatic wait_accept(input string name);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wr_prdy) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL %s accept timeout after 20 cycles", name);
  endtask

  task automatic put_word(input logic [DW-1:0] data);
    expect_write(data);
    wait_accept("put_word");
  endtask

  task automatic set_rd(input logic [AW:0] b);
    rd_model    = b;
    rd_ptr_gray = to_gray(b);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (ram_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write wa=%0d wd=%0h expected=no write", ram_wa, ram_wd);
        end else begin
          mon_w = exp_q.pop_front();
          if (ram_wa !== mon_w.wa || ram_wd !== mon_w.wd) begin
            errors++;
            $display("FAIL ram_write actual wa=%0d wd=%0h expected wa=%0d wd=%0h",
                     ram_wa, ram_wd, mon_w.wa, mon_w.wd);
          end
        end
      end
      checks++;
      if (wr_count > (AW+1)'(DEPTH)) begin
        errors++;
        $display("FAIL count_bound actual=%0d expected<=%0d", wr_count, DEPTH);
      end
      if (wr_ptr_gray != prev_gray) begin
        checks++;
        if ($countones(wr_ptr_gray ^ prev_gray) != 1) begin
          errors++;
          $display("FAIL gray_step actual=%b expected one-bit change from %b", wr_ptr_gray, prev_gray);
        end
      end
    end
    prev_gray = wr_ptr_gray;
  end

  initial begin
    // Reset state, write held pending through reset release
    expect_write(8'hA0);
    @(negedge clk);
    check("rst_gray", int'(wr_ptr_gray), 0);
    check("rst_count", int'(wr_count), 0);
    check("rst_prdy", int'(wr_prdy), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("t1_prdy_first", int'(wr_prdy), 0);
    wait_accept("t1_w0");
    put_word(8'hA1);
    put_word(8'hA2);
    put_word(8'hA3);
    @(negedge clk);
    check("t1_full_prdy", int'(wr_prdy), 0);
    check("t1_full_count", int'(wr_count), 4);
    check("t1_full_gray", int'(wr_ptr_gray), 6);
    repeat (2) @(negedge clk);

    // Full release after the read pointer moves
    @(posedge clk);
    #1;
    expect_write(8'hB0);
    set_rd(3'd1);
    for (int i = 0; i < SS + 1; i++) begin
      @(negedge clk);
      check("t2_prdy_held", int'(wr_prdy), 0);
    end
    @(negedge clk);
    check("t2_prdy_release", int'(wr_prdy), 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t2_refull_prdy", int'(wr_prdy), 0);
    check("t2_refull_count", int'(wr_count), 4);
    @(posedge clk);
    #1 wr_pvld = 1'b0;

    // Streaming with reads: addresses wrap through 0..3
    for (int n = 0; n < 20; n++) begin
      set_rd(rd_model + 1'b1);
      put_word(DW'(8'h10 + n));
    end
    wr_pvld = 1'b0;
    set_rd(wr_model);
    repeat (SS + 3) @(posedge clk);
    @(negedge clk);
    check("drain_count", int'(wr_count), 0);
    check("drain_prdy", int'(wr_prdy), 1);

    // DFT enable low blocks writes and holds pointers
    @(posedge clk);
    #1;
    hold_gray = wr_ptr_gray;
    check("t4_gray_model", int'(hold_gray), int'(to_gray(wr_model)));
    wr_en_dft = 1'b0;
    expect_write(8'h55);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_we_off", int'(ram_we), 0);
      check("t4_gray_hold", int'(wr_ptr_gray), int'(hold_gray));
    end
    @(posedge clk);
    #1 wr_en_dft = 1'b1;
    @(negedge clk);
    check("t4_we_resume", int'(ram_we), 1);
    @(posedge clk);
    #1 wr_pvld = 1'b0;

    // Asynchronous reset mid-operation
    put_word(8'hC1);
    put_word(8'hC2);
    put_word(8'hC3);
    wr_pvld = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("t5_rst_gray", int'(wr_ptr_gray), 0);
    check("t5_rst_count", int'(wr_count), 0);
    check("t5_rst_prdy", int'(wr_prdy), 0);
    wr_model = '0;
    set_rd(3'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    put_word(8'hD0);
    wr_pvld = 1'b0;
    repeat (3) @(negedge clk);
    check("exp_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
